// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: multi-cycle RISC-V main controller; sequences each instruction,
// stalls on MemReady and counts retired instructions.
module multicycle_control_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       op,
  input  logic             Zero,
  input  logic             MemReady,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic             RegWrite,
  output logic             Illegal,
  output logic [CNT_W-1:0] InstrCount,
  output logic [3:0]       StateOut
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTER, EXECUTEI, ALUWB, JAL, BEQ
  } state_t;
  typedef struct packed {
    logic       fetch;
    logic       pc_update;
    logic       branch;
    logic       adr_src;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  state_t            state_q, state_d;
  ctrl_t             ctrl_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              retire;
  // Moore control word for a state; registered from the next state so it lines up with state_q.
  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH:    begin c.fetch = 1'b1; c.alu_src_b = 2'b10; c.result_src = 2'b10; end
      DECODE:   begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; end
      MEMADR:   begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; end
      MEMREAD:  c.adr_src = 1'b1;
      MEMWB:    begin c.result_src = 2'b01; c.reg_write = 1'b1; end
      MEMWRITE: begin c.adr_src = 1'b1; c.mem_write = 1'b1; end
      EXECUTER: begin c.alu_src_a = 2'b10; c.alu_op = 2'b10; end
      EXECUTEI: begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.alu_op = 2'b10; end
      ALUWB:    c.reg_write = 1'b1;
      JAL:      begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.pc_update = 1'b1; end
      BEQ:      begin c.alu_src_a = 2'b10; c.alu_op = 2'b01; c.branch = 1'b1; end
      default:  c = '0;
    endcase
    return c;
  endfunction
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:    state_d = MemReady ? DECODE : FETCH;
      DECODE:   state_d = (op == OP_LW || op == OP_SW) ? MEMADR :
                          (op == OP_R)   ? EXECUTER :
                          (op == OP_I)   ? EXECUTEI :
                          (op == OP_JAL) ? JAL :
                          (op == OP_BEQ) ? BEQ : FETCH;
      MEMADR:   state_d = (op == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  state_d = MemReady ? MEMWB : MEMREAD;
      MEMWRITE: state_d = MemReady ? FETCH : MEMWRITE;
      EXECUTER: state_d = ALUWB;
      EXECUTEI: state_d = ALUWB;
      JAL:      state_d = ALUWB;
      default:  state_d = FETCH;
    endcase
  end
  assign retire = (state_d == FETCH) &&
                  (state_q == MEMWB || state_q == MEMWRITE || state_q == ALUWB || state_q == BEQ);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      ctrl_q  <= decode(FETCH);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= decode(state_d);
      if (retire) cnt_q <= cnt_q + CNT_W'(1);
    end
  end
  // Strobes are gated by rst_n so nothing is written while reset is held.
  assign PCWrite    = rst_n & ((ctrl_q.fetch & MemReady) | ctrl_q.pc_update | (ctrl_q.branch & Zero));
  assign IRWrite    = rst_n & ctrl_q.fetch & MemReady;
  assign MemWrite   = rst_n & ctrl_q.mem_write;
  assign RegWrite   = rst_n & ctrl_q.reg_write;
  assign Illegal    = rst_n && state_q == DECODE &&
                      !(op inside {OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ});
  assign AdrSrc     = ctrl_q.adr_src;
  assign ResultSrc  = ctrl_q.result_src;
  assign ALUSrcA    = ctrl_q.alu_src_a;
  assign ALUSrcB    = ctrl_q.alu_src_b;
  assign ALUOp      = ctrl_q.alu_op;
  assign InstrCount = cnt_q;
  assign StateOut   = state_q;
endmodule
